pi_alu_seq: RTL and testbench
=============================

// Module: pi_alu_seq
// PURPOSE
//  Parametrised, sequential successor to the PI-controller ALU. Accepts one op per handshake:
//  add/sub with x1/x2/x4/x8 scaling, fixed-point signed multiply, or accum clear. Owns an
//  internal accumulator; results leave through a valid/ready output register.
//  Sits between the control sequencer and the motor-drive math (Pcomp/Icomp/Intgrl updates).
// PARAMETERS
//  DW        16  datapath / accumulator / in_a / in_b / out_data width
//  SAT_ADD_W 12  signed width add/sub results clamp to when in_sat=1
//  MUL_W     15  signed multiplier operand width (low MUL_W bits of in_a, in_b)
//  FRAC      12  fraction bits discarded from the product (Q-format shift)
//  SAT_MUL_W 15  signed width every multiply result clamps to (always saturated)
// PORTS
//  clk       in  1   clock, all state on rising edge
//  rst       in  1   synchronous, active-high reset
//  in_valid  in  1   command valid
//  in_ready  out 1   command accepted when in_valid&in_ready
//  in_op     in  2   0 ADD, 1 SUB, 2 MUL, 3 CLR
//  in_scale  in  2   left shift of in_a for ADD/SUB (x1,x2,x4,x8); ignored otherwise
//  in_sat    in  1   clamp ADD/SUB result to SAT_ADD_W
//  in_acc_src in 1   src1 = accumulator instead of in_b
//  in_acc_wr in  1   write result into accumulator on completion
//  in_a      in  DW  signed operand 0
//  in_b      in  DW  signed operand 1
//  out_valid out 1   result valid, held until out_ready
//  out_ready in  1   consumer ready
//  out_data  out DW  signed result, sign-extended to DW
//  out_sat   out 1   result was clamped
//  accum     out DW  current accumulator value
// BEHAVIOUR
//  - Reset: state IDLE, in_ready=1, out_valid=0, out_data=0, out_sat=0, accum=0. Reset mid-op aborts; no output.
//  - FSM: IDLE -(accept ADD/SUB/CLR)-> EXEC -> HOLD; IDLE -(accept MUL)-> MUL -(MUL_W iters)-> HOLD;
//    HOLD -(out_ready)-> IDLE. in_ready=1 only in IDLE; in_valid outside IDLE ignored.
//  - Operands (accum included when in_acc_src) captured at accept edge; later input changes ignored.
//  - ADD/SUB: s = src1 +/- (in_a<<<in_scale), computed in DW+4 bits. in_sat=1: clamp to
//    [-2^(SAT_ADD_W-1), 2^(SAT_ADD_W-1)-1] (12b: 0xF800/0x07FF sign-extended), out_sat=1 if clamped.
//    in_sat=0: wrap to DW, out_sat=0. out_valid rises 2 edges after accept.
//  - MUL: signed in_a[MUL_W-1:0]*src1[MUL_W-1:0], shift-add on magnitudes, one partial product per cycle,
//    sign fixed at end. p = product>>>FRAC, clamp to SAT_MUL_W signed (15b: 0x3FFF/0xC000 in 16b).
//    out_valid rises MUL_W+1 edges after accept. in_scale, in_sat ignored.
//  - CLR: result 0, accum<=0 regardless of in_acc_wr, out_sat=0; timing as ADD.
//  - On entry to HOLD: out_data/out_sat registered; accum<=result if in_acc_wr. HOLD: outputs stable.
//  - out_valid&out_ready in HOLD: out_valid drops next edge, in_ready=1 same edge (1 bubble min).
// CONFIGURATION
//  PI_ALU_SAT_CNT_EN defined: extra port sat_cnt out 8; +1 per completed result with out_sat=1,
//    sticks at 0xFF, cleared by rst or CLR op.
//  Undefined: no sat_cnt port/logic; behaviour otherwise identical.
// STRUCTURE
//  pi_alu_pkg: op_t enum (OP_ADD,OP_SUB,OP_MUL,OP_CLR), state_t enum (IDLE,EXEC,MUL,HOLD),
//    saturating clamp function sat_to(value,width).
//  Sub-module pi_alu_seqmul: iterative MUL_W-cycle signed multiplier, start/done pulses, own sync rst.
//  Top: FSM, operand capture, add/sub path, clamps, accumulator, output register.
// TESTING (DW=16 defaults)
//  1 rst=1 two cycles -> out_valid=0, accum=0x0000, in_ready=1, out_data=0x0000.
//  2 accum=0x0010, ADD a=0x0003 scale=x4 acc_src=1 acc_wr=1 -> out_data=0x001C 2 edges later, accum=0x001C.
//  3 accum=0xF900, SUB a=0x0100 scale=x2 acc_src=1 sat=1 -> 0xF800, out_sat=1; sat=0 -> 0xF700, out_sat=0.
//  4 MUL a=0x1000 b=0x0800 -> 0x0800 at accept+16; a=0x3FFF b=0x3FFF -> 0x3FFF out_sat=1;
//    a=0x4000 (MUL_W-bit -16384) b=0x3FFF -> 0xC000 out_sat=1.
//  5 result in HOLD, out_ready=0 for 5 cycles, in_valid=1 -> out_data stable, in_ready=0, command ignored;
//    out_ready=1 -> out_valid=0 next edge.
//  6 rst at 5th MUL cycle -> no out_valid, accum=0, in_ready=1 next cycle; new ADD completes normally.

Source files
------------

// File: rtl/pi_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pi_alu_pkg
// Description : Shared types and helpers for the sequential PI-controller ALU.
//               Holds the op / state encodings and the signed clamp helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pi_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_CLR = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Clamp a signed value to the range of a 'width'-bit two's complement number.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] value,
                                                input int unsigned        width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pi_alu_seqmul.sv
`default_nettype none
// ============================================================================
// Module      : pi_alu_seqmul
// Description : Iterative signed multiplier. Works on operand magnitudes with
//               one shift-add partial product per clock and applies the sign
//               at the output. The first partial product is formed on the
//               start edge, so done pulses MUL_W-1 edges after start.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start_i       - load operands and begin (single-cycle pulse)
//               a_i, b_i      - MUL_W-bit signed operands
//               done_o        - one-cycle pulse, product_o valid from then on
//               product_o     - 2*MUL_W-bit signed product
// Revision    : 1.0 - initial release
// ============================================================================
module pi_alu_seqmul #(
  parameter int MUL_W = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic signed [MUL_W-1:0]   a_i,
  input  logic signed [MUL_W-1:0]   b_i,
  output logic                      done_o,
  output logic signed [2*MUL_W-1:0] product_o
);

  localparam int CW = $clog2(MUL_W + 1);

  logic [MUL_W-1:0]   a_mag;
  logic [MUL_W-1:0]   b_mag;
  logic [2*MUL_W-1:0] mcand_q;
  logic [2*MUL_W-1:0] prod_q;
  logic [MUL_W-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               neg_q;
  logic               done_q;

  // Magnitude of the most negative operand still fits as an unsigned MUL_W value.
  assign a_mag = a_i[MUL_W-1] ? (~a_i + 1'b1) : a_i;
  assign b_mag = b_i[MUL_W-1] ? (~b_i + 1'b1) : b_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        prod_q   <= b_mag[0] ? {{MUL_W{1'b0}}, a_mag} : '0;
        mcand_q  <= {{(MUL_W-1){1'b0}}, a_mag, 1'b0};
        mplier_q <= b_mag >> 1;
        cnt_q    <= CW'(1);
        busy_q   <= 1'b1;
        neg_q    <= a_i[MUL_W-1] ^ b_i[MUL_W-1];
      end else if (busy_q) begin
        if (mplier_q[0]) begin
          prod_q <= prod_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o    = done_q;
  assign product_o = neg_q ? -$signed(prod_q) : $signed(prod_q);

endmodule
`default_nettype wire

// File: rtl/pi_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : pi_alu_seq
// Description : Sequential PI-controller ALU. One command per valid/ready
//               handshake: scaled add/sub (optional clamp), fixed-point signed
//               multiply (always clamped), or accumulator clear. Result is
//               held in an output register until out_ready.
//               Optional feature macro: PI_ALU_SAT_CNT_EN adds the 8-bit
//               sticky saturation counter port sat_cnt.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               in_valid/in_ready     - command handshake
//               in_op, in_scale, in_sat, in_acc_src, in_acc_wr - command
//               in_a, in_b            - DW-bit signed operands
//               out_valid/out_ready   - result handshake
//               out_data, out_sat     - result and clamp flag
//               sat_cnt               - saturation count (macro only)
//               accum                 - accumulator value
// Revision    : 1.0 - initial release
// ============================================================================
module pi_alu_seq
  import pi_alu_pkg::*;
#(
  parameter int DW        = 16,
  parameter int SAT_ADD_W = 12,
  parameter int MUL_W     = 15,
  parameter int FRAC      = 12,
  parameter int SAT_MUL_W = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [1:0]    in_scale,
  input  logic          in_sat,
  input  logic          in_acc_src,
  input  logic          in_acc_wr,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sat,
`ifdef PI_ALU_SAT_CNT_EN
  output logic [7:0]    sat_cnt,
`endif
  output logic [DW-1:0] accum
);

  localparam int XW = DW + 4;
  localparam int PW = 2 * MUL_W;

  state_t        state_q, state_d;
  op_t           op_q;
  logic [1:0]    scale_q;
  logic          sat_en_q;
  logic          acc_wr_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] src1_q;
  logic [DW-1:0] accum_q;
  logic [DW-1:0] out_data_q;
  logic          out_sat_q;

  logic          accept;
  logic          hold_load;
  logic [DW-1:0] src1_in;
  logic          mul_start;
  logic          mul_done;

  logic signed [XW-1:0] add_a_ext;
  logic signed [XW-1:0] add_src_ext;
  logic signed [XW-1:0] add_sum;
  logic signed [63:0]   add_ext;
  logic signed [63:0]   add_clamped;
  logic signed [PW-1:0] mul_prod;
  logic signed [PW-1:0] mul_shift;
  logic signed [63:0]   mul_ext;
  logic signed [63:0]   mul_clamped;
  logic [DW-1:0]        res_d;
  logic                 res_sat_d;

  assign accept    = in_valid && in_ready;
  assign src1_in   = in_acc_src ? accum_q : in_b;
  assign mul_start = accept && (op_t'(in_op) == OP_MUL);

  // Multiplier takes operands straight from the accept-cycle mux so its
  // first partial product lands on the accept edge itself.
  pi_alu_seqmul #(
    .MUL_W (MUL_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (in_a[MUL_W-1:0]),
    .b_i       (src1_in[MUL_W-1:0]),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Add/sub path: four guard bits cover the x8 shift plus the carry.
  always_comb begin
    add_a_ext   = {{4{a_q[DW-1]}}, a_q} <<< scale_q;
    add_src_ext = {{4{src1_q[DW-1]}}, src1_q};
    add_sum     = (op_q == OP_SUB) ? (add_src_ext - add_a_ext) : (add_src_ext + add_a_ext);
    add_ext     = {{(64-XW){add_sum[XW-1]}}, add_sum};
    add_clamped = sat_to(add_ext, SAT_ADD_W);
  end

  // Multiply path: drop the fraction bits, then always clamp.
  always_comb begin
    mul_shift   = mul_prod >>> FRAC;
    mul_ext     = {{(64-PW){mul_shift[PW-1]}}, mul_shift};
    mul_clamped = sat_to(mul_ext, SAT_MUL_W);
  end

  // Result selection for the edge that enters HOLD.
  always_comb begin
    res_d     = '0;
    res_sat_d = 1'b0;
    if (state_q == MUL) begin
      res_d     = mul_clamped[DW-1:0];
      res_sat_d = (mul_clamped != mul_ext);
    end else if (op_q != OP_CLR) begin
      if (sat_en_q) begin
        res_d     = add_clamped[DW-1:0];
        res_sat_d = (add_clamped != add_ext);
      end else begin
        res_d     = add_sum[DW-1:0];
        res_sat_d = 1'b0;
      end
    end
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    hold_load = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (op_t'(in_op) == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        state_d   = HOLD;
        hold_load = 1'b1;
      end
      MUL: begin
        if (mul_done) begin
          state_d   = HOLD;
          hold_load = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_ADD;
      scale_q    <= '0;
      sat_en_q   <= 1'b0;
      acc_wr_q   <= 1'b0;
      a_q        <= '0;
      src1_q     <= '0;
      accum_q    <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= op_t'(in_op);
        scale_q  <= in_scale;
        sat_en_q <= in_sat;
        acc_wr_q <= in_acc_wr;
        a_q      <= in_a;
        src1_q   <= src1_in;
      end
      if (hold_load) begin
        out_data_q <= res_d;
        out_sat_q  <= res_sat_d;
        if (op_q == OP_CLR) begin
          accum_q <= '0;
        end else if (acc_wr_q) begin
          accum_q <= res_d;
        end
      end
    end
  end

`ifdef PI_ALU_SAT_CNT_EN
  logic [7:0] sat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else if (hold_load) begin
      if (op_q == OP_CLR) begin
        sat_cnt_q <= '0;
      end else if (res_sat_d && (sat_cnt_q != 8'hFF)) begin
        sat_cnt_q <= sat_cnt_q + 8'd1;
      end
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign accum     = accum_q;

endmodule
`default_nettype wire

// File: tb/tb_pi_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pi_alu_seq
// Description : Directed self-checking bench for pi_alu_seq (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_alu_seq;
  import pi_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [1:0]  in_scale = 2'd0;
  logic        in_sat = 1'b0;
  logic        in_acc_src = 1'b0;
  logic        in_acc_wr = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;
  logic [15:0] accum;
`ifdef PI_ALU_SAT_CNT_EN
  logic [7:0]  sat_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pi_alu_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_scale   (in_scale),
    .in_sat     (in_sat),
    .in_acc_src (in_acc_src),
    .in_acc_wr  (in_acc_wr),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
`ifdef PI_ALU_SAT_CNT_EN
    .sat_cnt    (sat_cnt),
`endif
    .accum      (accum)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command for a single accept edge; returns just after that edge.
  task automatic issue(input logic [1:0] op, input logic [1:0] scale, input logic sat,
                       input logic acc_src, input logic acc_wr,
                       input logic [15:0] a, input logic [15:0] b);
    in_op      = op;
    in_scale   = scale;
    in_sat     = sat;
    in_acc_src = acc_src;
    in_acc_wr  = acc_wr;
    in_a       = a;
    in_b       = b;
    in_valid   = 1'b1;
    cyc();
    in_valid   = 1'b0;
    in_a       = 16'hDEAD;
    in_b       = 16'hBEEF;
  endtask

  // Short op: result visible after the second edge counting the accept edge.
  task automatic run_short(input string tag, input logic [15:0] exp_data, input logic exp_sat);
    check({tag, "_busy"}, {31'd0, out_valid}, 32'd0);
    cyc();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, exp_data});
    check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, exp_sat});
  endtask

  // Multiply: result visible 16 edges after accept counting the accept edge.
  task automatic run_mul(input string tag, input logic [15:0] exp_data, input logic exp_sat);
    for (int i = 0; i < 14; i++) cyc();
    check({tag, "_busy"}, {31'd0, out_valid}, 32'd0);
    cyc();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, exp_data});
    check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, exp_sat});
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // 1: reset
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_accum", {16'd0, accum}, 32'h0000);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_data", {16'd0, out_data}, 32'h0000);

    // 2: load accum=0x0010, then accum + (3<<2)
    issue(OP_ADD, 2'd0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000);
    run_short("ld10", 16'h0010, 1'b0);
    release_out("ld10");
    issue(OP_ADD, 2'd2, 1'b0, 1'b1, 1'b1, 16'h0003, 16'h0000);
    run_short("add_x4", 16'h001C, 1'b0);
    check("add_x4_accum", {16'd0, accum}, 32'h001C);
    release_out("add_x4");

    // 3: accum=0xF900, SUB 0x100<<1 with and without clamp
    issue(OP_CLR, 2'd0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678);
    run_short("clr", 16'h0000, 1'b0);
    check("clr_accum", {16'd0, accum}, 32'h0000);
    release_out("clr");
    issue(OP_ADD, 2'd0, 1'b0, 1'b1, 1'b1, 16'hF900, 16'h0000);
    run_short("ldF9", 16'hF900, 1'b0);
    release_out("ldF9");
    issue(OP_SUB, 2'd1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000);
    run_short("sub_sat", 16'hF800, 1'b1);
    release_out("sub_sat");
    issue(OP_SUB, 2'd1, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);
    run_short("sub_wrap", 16'hF700, 1'b0);
    check("sub_wrap_accum", {16'd0, accum}, 32'hF900);
    release_out("sub_wrap");

    // 4: multiplies
    issue(OP_MUL, 2'd3, 1'b1, 1'b0, 1'b1, 16'h1000, 16'h0800);
    run_mul("mul_q", 16'h0800, 1'b0);
    check("mul_q_accum", {16'd0, accum}, 32'h0800);
    release_out("mul_q");
    issue(OP_MUL, 2'd0, 1'b0, 1'b0, 1'b0, 16'h3FFF, 16'h3FFF);
    run_mul("mul_pos", 16'h3FFF, 1'b1);
    release_out("mul_pos");
    issue(OP_MUL, 2'd0, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h3FFF);
    run_mul("mul_neg", 16'hC000, 1'b1);
    release_out("mul_neg");
    // 15-bit 0x7000 is -4096: -4096*2048 >> 12 = -2048
    issue(OP_MUL, 2'd0, 1'b0, 1'b0, 1'b0, 16'h7000, 16'h0800);
    run_mul("mul_sgn", 16'hF800, 1'b0);

    // 5: hold result with a pending command that must be ignored
    for (int i = 0; i < 5; i++) begin
      in_op    = OP_CLR;
      in_valid = 1'b1;
      cyc();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {16'd0, out_data}, 32'hF800);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_out("hold");
    check("hold_accum", {16'd0, accum}, 32'h0800);
    cyc();
    check("hold_idle", {31'd0, out_valid}, 32'd0);

    // 6: reset in the 5th multiply cycle aborts the op
    issue(OP_MUL, 2'd0, 1'b0, 1'b0, 1'b1, 16'h1000, 16'h0800);
    for (int i = 0; i < 4; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_accum", {16'd0, accum}, 32'h0000);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 16; i++) cyc();
    check("abort_quiet", {31'd0, out_valid}, 32'd0);
    issue(OP_ADD, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0007);
    run_short("post_add", 16'h000C, 1'b0);
    check("post_accum", {16'd0, accum}, 32'h000C);
    release_out("post_add");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
